mod_mem_viewer: RTL and testbench

MOD_MEM_VIEWER -- requirements
Module: mod_mem_viewer

---
 rtl/mod_mem_viewer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mod_mem_viewer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mem_viewer.sv
// ---------------------------------------------------------------------------
// mod_mem_viewer
//   Front panel for browsing a data memory. Two push buttons move a viewing
//   pointer. The pointer itself, or the memory word it addresses, is
//   converted to display digits: a hex nibble window selected by page, or
//   the low DIGITS decimal digits from a double-dabble engine. The block
//   also divides clk down to a 50% duty processor clock and registers the
//   processor's hold (program end) flag.
//
//   Optional feature: define MEM_VIEWER_AUTOREPEAT_EN to make a held button
//   repeat its step every REPEAT cycles. Without it, each press gives one
//   step and no repeat counter exists.
//
//   Ports
//     clk            system clock, all state on posedge
//     reset          asynchronous, active low
//     show_mem_ptr   1 = display pointer, 0 = display mem_data
//     incr_mem_ptr   raw increment button
//     dcr_mem_ptr    raw decrement button
//     hex_or_dec     1 = hex, 0 = decimal
//     page[1:0]      hex nibble window select
//     hold           processor program-end flag
//     mem_data       memory word at mem_ptr (combinational read)
//     mem_ptr[31:0]  viewing pointer, wraps modulo MEM_DEPTH
//     proc_clk       divided clock, CLK_DIV cycles per period
//     digits         4*DIGITS digit codes, digit 0 in bits [3:0]
//     dec_ovf        decimal value needs more than DIGITS digits
//     completed      hold registered
//     not_completed  ~hold registered
// ---------------------------------------------------------------------------

// Per-button path: 2-flop synchroniser, counter debouncer, rising-edge step.
module mod_mem_viewer_btn #(
    parameter int DEBOUNCE = 65536,
    parameter int REPEAT   = 8000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_step
);
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_db;
    logic            r_db_prev;
    logic            w_rise;

    // The level flips only on the DEBOUNCE-th consecutive differing sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= '0;
            r_db_cnt  <= '0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_db_prev <= r_db;
            if (r_sync[1] == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
                r_db     <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_rise = r_db & ~r_db_prev;

`ifdef MEM_VIEWER_AUTOREPEAT_EN
    localparam int RP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic [RP_W-1:0] r_rep_cnt;
    logic            w_rep;

    // Restarts on the initial step so repeats land REPEAT cycles apart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        r_rep_cnt <= '0;
        else if (!r_db || w_rise || w_rep) r_rep_cnt <= '0;
        else                               r_rep_cnt <= r_rep_cnt + 1'b1;
    end

    assign w_rep  = r_db && !w_rise && (r_rep_cnt == RP_W'(REPEAT - 1));
    assign o_step = w_rise | w_rep;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = (REPEAT == 0);
    assign o_step          = w_rise;
`endif
endmodule

module mod_mem_viewer #(
    parameter int DIGITS    = 4,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int CLK_DIV   = 15000,
    parameter int DEBOUNCE  = 65536,
    parameter int REPEAT    = 8000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  show_mem_ptr,
    input  logic                  incr_mem_ptr,
    input  logic                  dcr_mem_ptr,
    input  logic                  hex_or_dec,
    input  logic [1:0]            page,
    input  logic                  hold,
    input  logic [DATA_W-1:0]     mem_data,
    output logic [31:0]           mem_ptr,
    output logic                  proc_clk,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  dec_ovf,
    output logic                  completed,
    output logic                  not_completed
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // One spare BCD digit beyond what DATA_W needs, so the top digit never
    // overflows during the add-3 step.
    localparam int BCD_D = (DATA_W * 3) / 10 + 2;
    localparam int SH_W  = BCD_D * 4 + DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PAD_W = 4 * (BCD_D + 8);
    localparam logic [31:0] PTR_MAX = 32'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    // ---------------- processor clock divider ----------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_proc_clk;

    // High while the counter is in the first half of the period; the first
    // edge after reset sees count 0 and drives proc_clk high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_cnt  <= '0;
            r_proc_clk <= 1'b0;
        end else begin
            r_proc_clk <= (r_div_cnt < DIV_W'(CLK_DIV / 2));
            r_div_cnt  <= (r_div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : r_div_cnt + 1'b1;
        end
    end

    // ---------------- buttons and pointer ----------------
    logic [1:0] w_btn;
    logic [1:0] w_step;   // [0] incr, [1] dcr
    logic [31:0] r_mem_ptr;

    assign w_btn = {dcr_mem_ptr, incr_mem_ptr};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        mod_mem_viewer_btn #(.DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)) u_btn (
            .clk   (clk),
            .reset (reset),
            .i_btn (w_btn[g]),
            .o_step(w_step[g])
        );
    end

    // Coincident steps cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_mem_ptr <= '0;
        else if (w_step[0] && !w_step[1])
            r_mem_ptr <= (r_mem_ptr == PTR_MAX) ? '0 : r_mem_ptr + 1'b1;
        else if (w_step[1] && !w_step[0])
            r_mem_ptr <= (r_mem_ptr == '0) ? PTR_MAX : r_mem_ptr - 1'b1;
    end

    // ---------------- conversion FSM ----------------
    state_t r_state, w_next;
    logic   w_load, w_shift, w_done;
    logic [CNT_W-1:0] r_bit_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = S_LOAD;
            S_LOAD:  w_next = hex_or_dec ? S_DONE : S_SHIFT;
            S_SHIFT: w_next = (r_bit_cnt == CNT_W'(DATA_W - 1)) ? S_DONE : S_SHIFT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load  = (r_state == S_LOAD);
        w_shift = (r_state == S_SHIFT);
        w_done  = (r_state == S_DONE);
    end

    // ---------------- datapath ----------------
    // r_shift = {BCD digits, binary}; in hex mode the binary half keeps the
    // captured source untouched until DONE.
    logic [SH_W-1:0]     r_shift;
    logic                r_hex;
    logic [1:0]          r_page;
    logic [SH_W-1:0]     w_adj;
    logic [DATA_W-1:0]   w_src;
    logic [127:0]        w_src_ext;
    logic [PAD_W-1:0]    w_bcd_pad;
    logic [4*DIGITS-1:0] w_hex_digits;
    logic [4*DIGITS-1:0] w_dec_digits;
    logic                w_ovf;
    logic [4*DIGITS-1:0] r_digits;
    logic                r_dec_ovf;

    assign w_src = show_mem_ptr ? r_mem_ptr[DATA_W-1:0] : mem_data;

    always_comb begin
        w_adj = r_shift;
        for (int j = 0; j < BCD_D; j++)
            if (r_shift[DATA_W+4*j +: 4] >= 4'd5)
                w_adj[DATA_W+4*j +: 4] = r_shift[DATA_W+4*j +: 4] + 4'd3;
    end

    // Zero padding makes nibbles past DATA_W (and BCD digits past BCD_D)
    // read as 0 without range-dependent branches.
    assign w_src_ext = 128'(r_shift[DATA_W-1:0]);
    assign w_bcd_pad = PAD_W'(r_shift[SH_W-1:DATA_W]);
    assign w_ovf     = |(w_bcd_pad >> (4 * DIGITS));

    always_comb begin
        w_hex_digits = '0;
        w_dec_digits = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_hex_digits[4*i +: 4] = 4'(w_src_ext >> (4 * (int'(r_page) * DIGITS + i)));
            w_dec_digits[4*i +: 4] = w_bcd_pad[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_hex     <= 1'b0;
            r_page    <= '0;
            r_bit_cnt <= '0;
            r_digits  <= '0;
            r_dec_ovf <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift   <= SH_W'(w_src);
                r_hex     <= hex_or_dec;
                r_page    <= page;
                r_bit_cnt <= '0;
            end
            if (w_shift) begin
                r_shift   <= w_adj << 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_done) begin
                r_digits  <= r_hex ? w_hex_digits : w_dec_digits;
                r_dec_ovf <= r_hex ? 1'b0 : w_ovf;
            end
        end
    end

    // ---------------- completion flags ----------------
    logic r_completed, r_not_completed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_completed     <= 1'b0;
            r_not_completed <= 1'b1;
        end else begin
            r_completed     <= hold;
            r_not_completed <= ~hold;
        end
    end

    assign mem_ptr       = r_mem_ptr;
    assign proc_clk      = r_proc_clk;
    assign digits        = r_digits;
    assign dec_ovf       = r_dec_ovf;
    assign completed     = r_completed;
    assign not_completed = r_not_completed;
endmodule

// File: tb/tb_mod_mem_viewer.sv
module tb_mod_mem_viewer;
    localparam int DIGITS    = 4;
    localparam int DATA_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam int CLK_DIV   = 10;
    localparam int DEBOUNCE  = 4;
    localparam int REPEAT    = 100;
    localparam int SETTLE    = 80;   // covers an in-flight plus a full decimal conversion

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        show_mem_ptr = 1'b0;
    logic        incr_mem_ptr = 1'b0;
    logic        dcr_mem_ptr = 1'b0;
    logic        hex_or_dec = 1'b1;
    logic [1:0]  page = 2'd0;
    logic        hold = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic [31:0] mem_ptr;
    logic        proc_clk;
    logic [15:0] digits;
    logic        dec_ovf;
    logic        completed;
    logic        not_completed;

    int checks = 0;
    int failures = 0;
    int exp_ptr = 0;

    mod_mem_viewer #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH),
        .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .REPEAT(REPEAT)
    ) dut (
        .clk(clk), .reset(reset), .show_mem_ptr(show_mem_ptr),
        .incr_mem_ptr(incr_mem_ptr), .dcr_mem_ptr(dcr_mem_ptr),
        .hex_or_dec(hex_or_dec), .page(page), .hold(hold), .mem_data(mem_data),
        .mem_ptr(mem_ptr), .proc_clk(proc_clk), .digits(digits), .dec_ovf(dec_ovf),
        .completed(completed), .not_completed(not_completed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hx;
        logic [1:0]  pg;
        logic [31:0] data;
        logic [15:0] dig;
        logic        ovf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference conversion straight from the display rules.
    function automatic logic [16:0] model(input logic [31:0] v, input logic hx, input logic [1:0] pg);
        logic [15:0] d;
        longint      x;
        int          n;
        d = '0;
        x = longint'(v);
        for (int i = 0; i < DIGITS; i++) begin
            if (hx) begin
                n = int'(pg) * DIGITS + i;
                d[4*i +: 4] = (n < 8) ? 4'((v >> (4 * n)) & 32'hF) : 4'd0;
            end else begin
                d[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return {(!hx && v >= 32'd10000), d};
    endfunction

    // btn: 0 = incr, 1 = dcr, 2 = both
    task automatic press(input int btn, input int len);
        @(negedge clk);
        incr_mem_ptr = (btn != 1);
        dcr_mem_ptr  = (btn != 0);
        cyc(len);
        incr_mem_ptr = 1'b0;
        dcr_mem_ptr  = 1'b0;
        cyc(20);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc(2);
        exp_ptr = 0;
    endtask

    // Release reset and walk edge by edge: proc_clk pattern, digits still 0
    // one edge before the conversion lands, correct on the landing edge.
    task automatic release_check(input string tag, input int lat,
                                 input logic [15:0] exp_d, input logic exp_o);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            cyc(1);
            chk({tag, "_proc_clk"}, 64'(proc_clk), 64'(((k - 1) % CLK_DIV) < CLK_DIV / 2));
            if (k == 1) chk({tag, "_completed"}, 64'({completed, not_completed}), 64'({hold, ~hold}));
            if (k == lat - 1) chk({tag, "_digits_early"}, 64'({dec_ovf, digits}), 64'(0));
            if (k == lat)     chk({tag, "_digits"}, 64'({dec_ovf, digits}), 64'({exp_o, exp_d}));
        end
    endtask

    initial begin
        logic [16:0] e;
        logic [31:0] src;
        int          dir;

        tbl[0]  = '{1'b0, 2'd0, 32'd12345,     16'h2345, 1'b1};
        tbl[1]  = '{1'b0, 2'd0, 32'd987,       16'h0987, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 32'hDEADBEEF,  16'hBEEF, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 32'hDEADBEEF,  16'hDEAD, 1'b0};
        tbl[4]  = '{1'b1, 2'd2, 32'hDEADBEEF,  16'h0000, 1'b0};
        tbl[5]  = '{1'b1, 2'd3, 32'hDEADBEEF,  16'h0000, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 32'd9999,      16'h9999, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 32'd10000,     16'h0000, 1'b1};
        tbl[8]  = '{1'b0, 2'd0, 32'hFFFFFFFF,  16'h7295, 1'b1};
        tbl[9]  = '{1'b0, 2'd0, 32'd0,         16'h0000, 1'b0};
        tbl[10] = '{1'b1, 2'd1, 32'h12345678,  16'h1234, 1'b0};

        // Reset values while reset is held
        #2 reset = 1'b0;
        hold = 1'b1;
        hex_or_dec = 1'b1;
        mem_data = 32'hDEADBEEF;
        cyc(2);
        chk("rst_mem_ptr", 64'(mem_ptr), 64'(0));
        chk("rst_digits", 64'({dec_ovf, digits}), 64'(0));
        chk("rst_proc_clk", 64'(proc_clk), 64'(0));
        chk("rst_completed", 64'({completed, not_completed}), 64'(2'b01));

        // Hex latency and divider from reset release
        release_check("hex_lat", 3, 16'hBEEF, 1'b0);
        for (int k = 4; k <= 2 * CLK_DIV; k++) begin
            cyc(1);
            chk("proc_clk_run", 64'(proc_clk), 64'(((k - 1) % CLK_DIV) < CLK_DIV / 2));
        end

        // Decimal latency
        assert_reset();
        hex_or_dec = 1'b0;
        mem_data = 32'd12345;
        hold = 1'b0;
        release_check("dec_lat", DATA_W + 3, 16'h2345, 1'b1);

        // Table of conversions
        for (int t = 0; t < 11; t++) begin
            hex_or_dec = tbl[t].hx;
            page = tbl[t].pg;
            mem_data = tbl[t].data;
            cyc(SETTLE);
            chk($sformatf("tbl%0d", t), 64'({dec_ovf, digits}), 64'({tbl[t].ovf, tbl[t].dig}));
        end

        // Debounce and pointer wrap
        chk("ptr_start", 64'(mem_ptr), 64'(0));
        press(0, 3);
        chk("ptr_short_pulse", 64'(mem_ptr), 64'(0));
        press(0, 10);
        chk("ptr_incr", 64'(mem_ptr), 64'(1));
        press(1, 10);
        chk("ptr_dcr", 64'(mem_ptr), 64'(0));
        press(1, 10);
        chk("ptr_wrap_down", 64'(mem_ptr), 64'(MEM_DEPTH - 1));
        press(0, 10);
        chk("ptr_wrap_up", 64'(mem_ptr), 64'(0));
        press(2, 10);
        chk("ptr_both", 64'(mem_ptr), 64'(0));

        // Long hold: repeats only with the optional feature
        press(0, 360);
`ifdef MEM_VIEWER_AUTOREPEAT_EN
        exp_ptr = 4;
`else
        exp_ptr = 1;
`endif
        chk("ptr_long_hold", 64'(mem_ptr), 64'(exp_ptr));

        // Asynchronous reset in the middle of a decimal conversion
        hold = 1'b1;
        hex_or_dec = 1'b0;
        page = 2'd0;
        mem_data = 32'd987;
        cyc(SETTLE);
        chk("pre_rst_digits", 64'({dec_ovf, digits}), 64'(16'h0987));
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_ptr", 64'(mem_ptr), 64'(0));
        chk("async_digits", 64'({dec_ovf, digits}), 64'(0));
        chk("async_proc_clk", 64'(proc_clk), 64'(0));
        chk("async_completed", 64'({completed, not_completed}), 64'(2'b01));
        exp_ptr = 0;
        cyc(2);
        release_check("dec_after_rst", DATA_W + 3, 16'h0987, 1'b0);

        // Random presses and conversions against the model
        for (int r = 0; r < 16; r++) begin
            dir = int'($urandom_range(0, 2));
            press(dir, int'($urandom_range(6, 12)));
            if (dir == 0) exp_ptr = (exp_ptr + 1) % MEM_DEPTH;
            if (dir == 1) exp_ptr = (exp_ptr + MEM_DEPTH - 1) % MEM_DEPTH;
            chk($sformatf("rnd_ptr%0d", r), 64'(mem_ptr), 64'(exp_ptr));

            show_mem_ptr = 1'($urandom_range(0, 1));
            hex_or_dec = 1'($urandom_range(0, 1));
            page = 2'($urandom_range(0, 3));
            mem_data = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20000) : $urandom;
            src = show_mem_ptr ? 32'(exp_ptr) : mem_data;
            cyc(SETTLE);
            e = model(src, hex_or_dec, page);
            chk($sformatf("rnd_conv%0d", r), 64'({dec_ovf, digits}), 64'(e));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
